// File: rtl/apb_master_bridge.sv
// APB3 requester: converts a valid/ready request into one SETUP/ACCESS
// transfer at a time and returns the result on a valid/ready response port.
// An optional PREADY timeout ends a stalled ACCESS phase with an error.
module apb_master_bridge #(
    parameter int AddrW         = 11,
    parameter int DataW         = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    // request port
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [AddrW-1:0] req_addr_i,
    input  logic [DataW-1:0] req_wdata_i,
    // response port
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [DataW-1:0] rsp_rdata_o,
    output logic             rsp_error_o,
    output logic             rsp_timeout_o,
    // APB requester side
    output logic [AddrW-1:0] PADDR,
    output logic             PSELx,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [DataW-1:0] PWDATA,
    input  logic             PREADY,
    input  logic [DataW-1:0] PRDATA,
    input  logic             PSLVERR
);

    localparam int CntW = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast =
        (TimeoutCycles == 0) ? '0 : CntW'(TimeoutCycles - 1);
    localparam bit TimeoutEn = (TimeoutCycles != 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t          state;
    logic [CntW-1:0] cnt;

    // A request is only taken while no transfer or response is in flight
    assign req_ready_o = (state == IDLE);

    // Transfer sequencing with registered APB and response outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state         <= IDLE;
            cnt           <= '0;
            PADDR         <= '0;
            PWDATA        <= '0;
            PWRITE        <= 1'b0;
            PSELx         <= 1'b0;
            PENABLE       <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_error_o   <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        PADDR   <= req_addr_i;
                        PWRITE  <= req_write_i;
                        PWDATA  <= req_wdata_i;
                        PSELx   <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end else begin
                        PSELx <= 1'b0;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY is checked first so it wins over a coincident timeout
                    if (PREADY) begin
                        PSELx         <= 1'b0;
                        PENABLE       <= 1'b0;
                        rsp_rdata_o   <= PWRITE ? '0 : PRDATA;
                        rsp_error_o   <= PSLVERR;
                        rsp_timeout_o <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        state         <= RESP;
                    end else if (TimeoutEn && (cnt == CntLast)) begin
                        PSELx         <= 1'b0;
                        PENABLE       <= 1'b0;
                        rsp_rdata_o   <= '0;
                        rsp_error_o   <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        rsp_valid_o   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt + CntW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed testbench for apb_master_bridge with hand-computed expectations.
module tb_apb_master_bridge;

    localparam int AddrW = 11;
    localparam int DataW = 32;
    localparam int TCyc  = 16;

    logic             PCLK = 1'b0;
    logic             PRESET;
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_write_i;
    logic [AddrW-1:0] req_addr_i;
    logic [DataW-1:0] req_wdata_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [DataW-1:0] rsp_rdata_o;
    logic             rsp_error_o;
    logic             rsp_timeout_o;
    logic [AddrW-1:0] PADDR;
    logic             PSELx;
    logic             PENABLE;
    logic             PWRITE;
    logic [DataW-1:0] PWDATA;
    logic             PREADY;
    logic [DataW-1:0] PRDATA;
    logic             PSLVERR;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    apb_master_bridge #(
        .AddrW        (AddrW),
        .DataW        (DataW),
        .TimeoutCycles(TCyc)
    ) dut (
        .PCLK         (PCLK),
        .PRESET       (PRESET),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_error_o  (rsp_error_o),
        .rsp_timeout_o(rsp_timeout_o),
        .PADDR        (PADDR),
        .PSELx        (PSELx),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PWDATA       (PWDATA),
        .PREADY       (PREADY),
        .PRDATA       (PRDATA),
        .PSLVERR      (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock and settle just past the edge
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // present a request for exactly one accept edge, then scramble the inputs
    task automatic issue(input logic wr, input logic [AddrW-1:0] a, input logic [DataW-1:0] d);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = a;
        req_wdata_i = d;
        tick();
        req_valid_i = 1'b0;
        req_write_i = ~wr;
        req_addr_i  = 11'h7FF;
        req_wdata_i = 32'hFFFF_0000;
    endtask

    task automatic check_apb(input string tag, input logic sel, input logic en);
        check_eq({tag, ".psel"}, 64'(PSELx), 64'(sel));
        check_eq({tag, ".pen"},  64'(PENABLE), 64'(en));
    endtask

    task automatic check_rsp(input string tag, input logic [DataW-1:0] rd, input logic err, input logic to);
        check_eq({tag, ".rvalid"}, 64'(rsp_valid_o), 64'(1));
        check_eq({tag, ".rdata"},  64'(rsp_rdata_o), 64'(rd));
        check_eq({tag, ".rerr"},   64'(rsp_error_o), 64'(err));
        check_eq({tag, ".rto"},    64'(rsp_timeout_o), 64'(to));
    endtask

    initial begin
        PRESET      = 1'b1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b1;
        PREADY      = 1'b0;
        PRDATA      = '0;
        PSLVERR     = 1'b0;
        tick();
        tick();

        // reset state
        check_apb("rst", 1'b0, 1'b0);
        check_eq("rst.rvalid", 64'(rsp_valid_o), 64'(0));
        check_eq("rst.rdy",    64'(req_ready_o), 64'(1));
        check_eq("rst.paddr",  64'(PADDR), 64'(0));
        check_eq("rst.pwdata", 64'(PWDATA), 64'(0));
        check_eq("rst.pwrite", 64'(PWRITE), 64'(0));
        check_eq("rst.rdata",  64'(rsp_rdata_o), 64'(0));
        PRESET = 1'b0;
        tick();

        // write, zero wait states; PRDATA nonzero to prove writes return 0
        PREADY = 1'b1;
        PRDATA = 32'hCAFE_F00D;
        issue(1'b1, 11'h01C, 32'hDEAD_BEEF);
        check_apb("wr.setup", 1'b1, 1'b0);
        check_eq("wr.setup.rdy", 64'(req_ready_o), 64'(0));
        tick();
        check_apb("wr.access", 1'b1, 1'b1);
        check_eq("wr.paddr",  64'(PADDR), 64'(11'h01C));
        check_eq("wr.pwdata", 64'(PWDATA), 64'(32'hDEAD_BEEF));
        check_eq("wr.pwrite", 64'(PWRITE), 64'(1));
        tick();
        check_apb("wr.resp", 1'b0, 1'b0);
        check_rsp("wr.resp", 32'h0, 1'b0, 1'b0);
        tick();
        check_eq("wr.done.rvalid", 64'(rsp_valid_o), 64'(0));
        check_eq("wr.done.rdy",    64'(req_ready_o), 64'(1));
        check_eq("wr.idle.paddr",  64'(PADDR), 64'(11'h01C));
        check_eq("wr.idle.psel",   64'(PSELx), 64'(0));

        // read with 3 wait states; PSLVERR while PREADY low must be ignored
        PREADY  = 1'b0;
        PSLVERR = 1'b1;
        issue(1'b0, 11'h040, 32'h1111_1111);
        tick();
        for (int i = 0; i < 3; i++) begin
            check_apb($sformatf("rd.wait%0d", i), 1'b1, 1'b1);
            check_eq($sformatf("rd.wait%0d.paddr", i), 64'(PADDR), 64'(11'h040));
            tick();
        end
        check_apb("rd.acc4", 1'b1, 1'b1);
        check_eq("rd.acc4.pwrite", 64'(PWRITE), 64'(0));
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = 32'h1234_5678;
        tick();
        check_apb("rd.resp", 1'b0, 1'b0);
        check_rsp("rd.resp", 32'h1234_5678, 1'b0, 1'b0);
        tick();

        // completer error on a read
        PSLVERR = 1'b1;
        PRDATA  = 32'hA5A5_A5A5;
        issue(1'b0, 11'h100, 32'h0);
        tick();
        tick();
        check_rsp("slverr", 32'hA5A5_A5A5, 1'b1, 1'b0);
        PSLVERR = 1'b0;
        tick();

        // timeout: PREADY held low for the full window
        PREADY = 1'b0;
        PRDATA = 32'h5555_AAAA;
        issue(1'b0, 11'h2AA, 32'h0);
        tick();
        for (int i = 0; i < TCyc; i++) begin
            check_apb($sformatf("to.acc%0d", i), 1'b1, 1'b1);
            tick();
        end
        check_apb("to.resp", 1'b0, 1'b0);
        check_rsp("to.resp", 32'h0, 1'b1, 1'b1);
        tick();

        // PREADY on the final window cycle wins over the timeout
        issue(1'b0, 11'h2AB, 32'h0);
        tick();
        for (int i = 0; i < TCyc - 1; i++) tick();
        check_apb("race.acc16", 1'b1, 1'b1);
        PREADY = 1'b1;
        PRDATA = 32'h0BAD_C0DE;
        tick();
        check_rsp("race.resp", 32'h0BAD_C0DE, 1'b0, 1'b0);
        tick();

        // response backpressure; a waiting request must not be taken in RESP
        rsp_ready_i = 1'b0;
        PRDATA      = 32'h7777_8888;
        issue(1'b0, 11'h0F0, 32'h0);
        tick();
        tick();
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 11'h333;
        req_wdata_i = 32'h0123_4567;
        for (int i = 0; i < 5; i++) begin
            check_rsp($sformatf("bp%0d", i), 32'h7777_8888, 1'b0, 1'b0);
            check_eq($sformatf("bp%0d.rdy", i), 64'(req_ready_o), 64'(0));
            check_eq($sformatf("bp%0d.psel", i), 64'(PSELx), 64'(0));
            tick();
        end
        rsp_ready_i = 1'b1;
        tick();
        check_eq("bp.idle.rvalid", 64'(rsp_valid_o), 64'(0));
        check_eq("bp.idle.rdy",    64'(req_ready_o), 64'(1));
        tick();
        req_valid_i = 1'b0;
        check_apb("bp.next.setup", 1'b1, 1'b0);
        check_eq("bp.next.paddr",  64'(PADDR), 64'(11'h333));
        check_eq("bp.next.pwdata", 64'(PWDATA), 64'(32'h0123_4567));

        // reset during ACCESS
        PREADY = 1'b0;
        tick();
        check_apb("mid.access", 1'b1, 1'b1);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        check_apb("mid.rst", 1'b0, 1'b0);
        check_eq("mid.rst.rvalid", 64'(rsp_valid_o), 64'(0));
        check_eq("mid.rst.paddr",  64'(PADDR), 64'(0));
        check_eq("mid.rst.pwdata", 64'(PWDATA), 64'(0));
        check_eq("mid.rst.rdy",    64'(req_ready_o), 64'(1));
        tick();
        check_eq("mid.after.psel", 64'(PSELx), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
